// File: rtl/touch_key_gen.sv
// Touch-key stimulus generator: turns one press command into a bouncing key waveform
// (bounce-in, hold, bounce-out, release gap) on a registered touch_key line.
module touch_key_gen #(
    parameter int BOUNCE_CYC = 4,
    parameter int BOUNCE_N   = 3,
    parameter int GAP_CYC    = 8,
    parameter int HOLD_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic              cmd_ready,
    output logic              touch_key,
    output logic              busy,
    output logic              done
);

    localparam int PHASE_MAX = (BOUNCE_CYC > GAP_CYC) ? BOUNCE_CYC : GAP_CYC;
    localparam int PW        = $clog2(PHASE_MAX + 1);
    localparam int NPH       = 2 * BOUNCE_N - 1;
    localparam int IW        = (NPH > 1) ? $clog2(NPH) : 1;

    localparam logic [PW-1:0]     BOUNCE_LOAD = PW'(BOUNCE_CYC);
    localparam logic [PW-1:0]     GAP_LOAD    = PW'(GAP_CYC);
    localparam logic [IW-1:0]     LAST_IDX    = IW'(NPH - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_IN,
        HOLD,
        BOUNCE_OUT,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              key_q, key_d;
    logic              done_q, done_d;
    logic              phase_last;
    logic              idx_last;

    assign busy       = (state_q != IDLE);
    assign cmd_ready  = ~busy;
    assign touch_key  = key_q;
    assign done       = done_q;
    assign phase_last = (phase_q == PW'(1));
    assign idx_last   = (idx_q == LAST_IDX);

    // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d = BOUNCE_IN;
                    phase_d = BOUNCE_LOAD;
                    idx_d   = '0;
                    hold_d  = (cmd_hold == '0) ? HOLD_ONE : cmd_hold;
                end
            end
            BOUNCE_IN, BOUNCE_OUT: begin
                if (!phase_last) begin
                    phase_d = phase_q - PW'(1);
                end else if (!idx_last) begin
                    idx_d   = idx_q + IW'(1);
                    phase_d = BOUNCE_LOAD;
                end else if (state_q == BOUNCE_IN) begin
                    state_d = HOLD;
                end else begin
                    state_d = GAP;
                    phase_d = GAP_LOAD;
                end
            end
            HOLD: begin
                if (hold_q == HOLD_ONE) begin
                    state_d = BOUNCE_OUT;
                    phase_d = BOUNCE_LOAD;
                    idx_d   = '0;
                end else begin
                    hold_d = hold_q - HOLD_ONE;
                end
            end
            GAP: begin
                if (phase_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    phase_d = phase_q - PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Key level follows the upcoming phase so the registered output lines up with the state.
        case (state_d)
            BOUNCE_IN:  key_d = ~idx_d[0];
            HOLD:       key_d = 1'b1;
            BOUNCE_OUT: key_d = idx_d[0];
            default:    key_d = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            key_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            key_q   <= key_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_touch_key_gen.sv
// Self-checking bench for touch_key_gen: a default-parameter and a clean-press instance,
// per-cycle scoreboard from a waveform model, plus reset, back-to-back and abort sequences.
`timescale 1ns/1ps
module tb_touch_key_gen;

    localparam int N_D = 3, C_D = 4, G_D = 8;
    localparam int N_C = 1, C_C = 2, G_C = 3;

    typedef struct packed {
        logic key;
        logic busy;
        logic done;
        logic ready;
    } obs_t;

    typedef struct {
        string name;
        int    which;
        int    hold;
        bit    noise;
        int    exp_len;
        int    exp_edges;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vd, vc;
    logic [15:0] hd, hc;
    logic        rdy_d, key_d, busy_d, done_d;
    logic        rdy_c, key_c, busy_c, done_c;

    int   checks = 0;
    int   errors = 0;
    obs_t sb_q[$];

    always #5 clk = ~clk;

    touch_key_gen #(.BOUNCE_CYC(C_D), .BOUNCE_N(N_D), .GAP_CYC(G_D), .HOLD_W(16)) u_def (
        .clk(clk), .rst(rst), .cmd_valid(vd), .cmd_hold(hd),
        .cmd_ready(rdy_d), .touch_key(key_d), .busy(busy_d), .done(done_d)
    );

    touch_key_gen #(.BOUNCE_CYC(C_C), .BOUNCE_N(N_C), .GAP_CYC(G_C), .HOLD_W(16)) u_clean (
        .clk(clk), .rst(rst), .cmd_valid(vc), .cmd_hold(hc),
        .cmd_ready(rdy_c), .touch_key(key_c), .busy(busy_c), .done(done_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic v, input logic [15:0] h);
        if (which == 0) begin
            vd = v;
            hd = h;
        end else begin
            vc = v;
            hc = h;
        end
    endtask

    function automatic obs_t sample(input int which);
        obs_t o;
        if (which == 0) o = '{key: key_d, busy: busy_d, done: done_d, ready: rdy_d};
        else            o = '{key: key_c, busy: busy_c, done: done_c, ready: rdy_c};
        return o;
    endfunction

    // Expected outputs in cycle k after the accepting edge, straight from the timing formula.
    function automatic obs_t model(input int n, input int c, input int g, input int h, input int k);
        obs_t e;
        int   bin = (2 * n - 1) * c;
        int   len = 2 * bin + h + g;
        e.busy  = (k >= 1 && k <= len);
        e.done  = (k == len + 1);
        e.ready = !e.busy;
        e.key   = 1'b0;
        if (k >= 1 && k <= bin)                 e.key = (((k - 1) / c) % 2) == 0;
        else if (k > bin && k <= bin + h)       e.key = 1'b1;
        else if (k > bin + h && k <= 2*bin + h) e.key = (((k - bin - h - 1) / c) % 2) == 1;
        return e;
    endfunction

    task automatic run_press(input string tag, input int which, input int hold, input bit noise,
                             input bit chained_in, input bit chain_out, input int next_hold,
                             input int abort_at, output int busy_cnt, output int edges);
        int   n, c, g, h_eff, len, last;
        logic prev;
        obs_t o, e;
        n     = (which == 0) ? N_D : N_C;
        c     = (which == 0) ? C_D : C_C;
        g     = (which == 0) ? G_D : G_C;
        h_eff = (hold == 0) ? 1 : hold;
        len   = 2 * (2 * n - 1) * c + h_eff + g;
        last  = (abort_at > 0) ? abort_at : len + 1;
        if (!chained_in) begin
            @(negedge clk);
            o = sample(which);
            check({tag, " ready_before"}, o.ready, 1'b1);
            drive(which, 1'b1, 16'(hold));
        end
        @(posedge clk);
        for (int k = 1; k <= last; k++) sb_q.push_back(model(n, c, g, h_eff, k));
        busy_cnt = 0;
        edges    = 0;
        prev     = 1'b0;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            o = sample(which);
            e = sb_q.pop_front();
            check($sformatf("%s key c%0d", tag, k), o.key, e.key);
            check($sformatf("%s busy c%0d", tag, k), o.busy, e.busy);
            check($sformatf("%s done c%0d", tag, k), o.done, e.done);
            check($sformatf("%s ready c%0d", tag, k), o.ready, e.ready);
            if (o.busy === 1'b1) busy_cnt++;
            if (o.key === 1'b1 && prev === 1'b0) edges++;
            prev = o.key;
            if (chain_out)  drive(which, 1'b1, 16'((k == last) ? next_hold : hold));
            else if (noise) drive(which, (k % 3 == 0) && (k < len), 16'($urandom_range(0, 65535)));
            else            drive(which, 1'b0, 16'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[5];
        int   bc, ed;
        logic led;

        vecs[0] = '{"def_h10",        0, 10,  1'b0, 58,  5};
        vecs[1] = '{"clean_h5",       1, 5,   1'b0, 12,  1};
        vecs[2] = '{"def_h0_noise",   0, 0,   1'b1, 49,  5};
        vecs[3] = '{"clean_h0_noise", 1, 0,   1'b1, 8,   1};
        vecs[4] = '{"def_h300",       0, 300, 1'b0, 348, 5};

        // Reset held three edges with commands offered: nothing may be accepted.
        rst = 1'b1;
        vd  = 1'b1;  hd = 16'd5;
        vc  = 1'b1;  hc = 16'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst key_d %0d", i), key_d, 1'b0);
            check($sformatf("rst busy_d %0d", i), busy_d, 1'b0);
            check($sformatf("rst done_d %0d", i), done_d, 1'b0);
            check($sformatf("rst ready_d %0d", i), rdy_d, 1'b1);
            check($sformatf("rst key_c %0d", i), key_c, 1'b0);
        end
        rst = 1'b0;
        vd  = 1'b0;
        vc  = 1'b0;
        @(negedge clk);
        check("post_rst key", key_d, 1'b0);
        check("post_rst ready", rdy_d, 1'b1);
        check("post_rst done", done_d, 1'b0);
        check("post_rst ready_c", rdy_c, 1'b1);

        for (int i = 0; i < 5; i++) begin
            run_press(vecs[i].name, vecs[i].which, vecs[i].hold, vecs[i].noise,
                      1'b0, 1'b0, 0, 0, bc, ed);
            check({vecs[i].name, " busy_len"}, bc, vecs[i].exp_len);
            check({vecs[i].name, " rise_edges"}, ed, vecs[i].exp_edges);
        end

        // Back-to-back with cmd_valid held: second acceptance lands in the done cycle.
        led = 1'b0;
        run_press("b2b_1", 0, 3, 1'b0, 1'b0, 1'b1, 7, 0, bc, ed);
        led = led ^ ed[0];
        check("b2b_1 busy_len", bc, 51);
        check("b2b_1 led", led, 1'b1);
        run_press("b2b_2", 0, 7, 1'b0, 1'b1, 1'b0, 0, 0, bc, ed);
        led = led ^ ed[0];
        check("b2b_2 busy_len", bc, 55);
        check("b2b_2 led", led, 1'b0);

        // Reset in the middle of HOLD aborts without a done pulse.
        run_press("abort", 0, 10, 1'b0, 1'b0, 1'b0, 0, 25, bc, ed);
        rst = 1'b1;
        @(negedge clk);
        check("abort key", key_d, 1'b0);
        check("abort busy", busy_d, 1'b0);
        check("abort done", done_d, 1'b0);
        check("abort ready", rdy_d, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("abort idle done %0d", i), done_d, 1'b0);
            check($sformatf("abort idle busy %0d", i), busy_d, 1'b0);
        end
        run_press("after_abort", 0, 10, 1'b0, 1'b0, 1'b0, 0, 0, bc, ed);
        check("after_abort busy_len", bc, 58);
        check("after_abort rise_edges", ed, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
